// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage in front of decode. The PC drives the word address
// of the instruction RAM. The RAM's combinational read data is captured
// together with the PC into a small circular prefetch queue. Decode takes
// words from the head of that queue with a valid/ready handshake.
//
// Control:
//   redirect - flushes the queue and loads a new PC. It has the highest
//              priority.
//   halt     - freezes the PC and stops pushes. The queue still drains.
//
// This port only reads the RAM. The write enable of this RAM port is tied low
// at the level above this module.
//
// Ports:
//   clock        in   system clock; all state updates on the rising edge
//   reset        in   asynchronous, active-low reset
//   mem_addr     out  RAM word address (always equal to the PC)
//   mem_data     in   RAM read data, combinational from mem_addr
//   instr_valid  out  the queue head holds a valid instruction
//   instr        out  instruction word at the queue head
//   instr_pc     out  word address of the queue head
//   instr_ready  in   decode accepts the head this cycle
//   redirect     in   flush the queue and load the PC from redirect_pc
//   redirect_pc  in   new fetch address
//   halt         in   suppress new fetches; the queue still drains
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                 ADDR_W      = 7,
    parameter int                 DATA_W      = 32,
    parameter int                 QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC    = {ADDR_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    // Pointers need 1 bit for two entries and 2 bits for three or four.
    // The count needs to reach QUEUE_DEPTH (at most 4).
    localparam int                PTR_W    = (QUEUE_DEPTH > 2) ? 2 : 1;
    localparam int                CNT_W    = 3;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

    // Circular-buffer increment. The pointer wraps modulo QUEUE_DEPTH, which
    // need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Architectural state
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_q_data [QUEUE_DEPTH];
    logic [ADDR_W-1:0] r_q_pc   [QUEUE_DEPTH];

    // Registered head outputs
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;

    // Next-state signals
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  w_next_count;
    logic [PTR_W-1:0]  w_next_rd;
    logic [PTR_W-1:0]  w_next_wr;
    logic [DATA_W-1:0] w_head_data;
    logic [ADDR_W-1:0] w_head_pc;

    // A redirect masks valid, so no transfer can happen in a flush cycle.
    assign w_valid   = (r_count != {CNT_W{1'b0}}) & ~redirect;
    assign w_pop     = w_valid & instr_ready;
    // A full queue accepts a push only when a pop frees a slot in the same cycle.
    assign w_push    = ~redirect & ~halt & ((r_count < DEPTH_C) | w_pop);
    assign w_next_rd = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    assign w_next_wr = ptr_inc(r_wr_ptr);

    // Occupancy after this cycle's push/pop (flush is handled in the register block)
    always_comb begin
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + CNT_W'(1);
            2'b01:   w_next_count = r_count - CNT_W'(1);
            default: w_next_count = r_count;
        endcase
    end

    // Select what the head registers show after the edge.
    // The newly written entry becomes the head only when it lands in the slot
    // the read pointer will point to. When the queue ends up empty, the
    // previous head is held.
    always_comb begin
        w_head_data = r_instr;
        w_head_pc   = r_instr_pc;
        if (redirect || (w_next_count == {CNT_W{1'b0}})) begin
            w_head_data = r_instr;
            w_head_pc   = r_instr_pc;
        end else if (w_push && (r_wr_ptr == w_next_rd)) begin
            w_head_data = mem_data;
            w_head_pc   = r_pc;
        end else begin
            w_head_data = r_q_data[w_next_rd];
            w_head_pc   = r_q_pc[w_next_rd];
        end
    end

    // PC, queue storage, pointers and occupancy
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_count  <= {CNT_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_data[i] <= {DATA_W{1'b0}};
                r_q_pc[i]   <= {ADDR_W{1'b0}};
            end
        end else if (redirect) begin
            r_pc     <= redirect_pc;
            r_count  <= {CNT_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_q_data[r_wr_ptr] <= mem_data;
                r_q_pc[r_wr_ptr]   <= r_pc;
                r_wr_ptr           <= w_next_wr;
                r_pc               <= r_pc + ADDR_W'(1);
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_next_count;
        end
    end

    // Head output registers; no path from mem_data to instr within a cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instr    <= {DATA_W{1'b0}};
            r_instr_pc <= {ADDR_W{1'b0}};
        end else begin
            r_instr    <= w_head_data;
            r_instr_pc <= w_head_pc;
        end
    end

    assign mem_addr    = r_pc;
    assign instr_valid = w_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of decode. It drives the word address of the 128x32 instruction RAM and captures the RAM's combinational read data in the same cycle. Fetched words go into a small prefetch queue, which presents them to decode with a valid/ready handshake. Branch/jump redirects flush the queue, and a halt input freezes fetching.

Parameters:
ADDR_W, 7, word-address width; RAM depth is 2^ADDR_W = 128 words
DATA_W, 32, instruction width
QUEUE_DEPTH, 2, prefetch queue entries (legal values 2..4)
RESET_PC, 0, word address loaded into PC on reset

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
mem_addr  output  ADDR_W  RAM word address; always equals PC
mem_data  input  DATA_W  RAM read data, combinational from mem_addr in the same cycle
instr_valid  output  1  queue head holds a valid instruction
instr  output  DATA_W  queue head instruction word
instr_pc  output  ADDR_W  word address of queue head
instr_ready  input  1  decode accepts head this cycle
redirect  input  1  flush and load PC from redirect_pc
redirect_pc  input  ADDR_W  new fetch address
halt  input  1  1: suppress new fetches; queue still drains

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC, count=0, read/write pointers=0, all queue entries zeroed.
  - Outputs: mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - Reset asserted mid-operation discards all queued words immediately.
- Fetch is read-only. The top level ties RAM wre=0 on this port.
- pop = instr_valid & instr_ready.
- instr_valid = (count!=0) & ~redirect, combinational.
- push = ~redirect & ~halt & (count<QUEUE_DEPTH | pop).
  - Push when full is allowed only with a simultaneous pop; count stays QUEUE_DEPTH.
- On push:
  - Entry {PC, mem_data} is written at the write pointer.
  - PC <= PC+1 modulo 2^ADDR_W, so 127 wraps to 0.
- Count update: push only +1; pop only -1; both unchanged; neither unchanged.
- Pointers wrap modulo QUEUE_DEPTH.
- Queue is a circular buffer; FIFO order is strictly preserved.
- instr and instr_pc show the head entry while count!=0. When count==0 they hold their last value (don't-care to decode).
- Latency: PC presented in cycle N is visible at the head in cycle N+1 if the queue was empty.
- Steady-state throughput is 1 instruction/cycle with instr_ready held 1.
- Redirect (highest priority) on the next edge:
  - count<=0, pointers<=0, PC<=redirect_pc.
  - No push and no pop that cycle; instr_valid is forced 0 so no transfer occurs.
  - First redirected word appears at the head one cycle after redirect deasserts, unless halt is 1.
- Halt:
  - PC frozen, no pushes.
  - Pops continue, so the queue drains to empty.
  - Deasserting halt resumes fetch at the frozen PC.
- Redirect with halt=1: flush and PC load still happen; fetch stays stopped.
- No bypass path: mem_data never reaches instr in the same cycle.
- No X propagation: every register has a reset value.

Test Plan:
- Reset release, boot image loaded (words 2/3/4 = 20000001/00000820/00201025), instr_ready=1 -> cycle1: instr_pc=0, valid=1; cycle3: instr=20000001, instr_pc=2; cycle4: 00000820; one instruction per cycle.
- instr_ready=0 for 5 cycles from reset -> count saturates at 2, PC stops at 2, head instr_pc=0. Then ready=1 -> outputs pc 0,1,2,3 consecutively with no gaps or duplicates.
- Pulse redirect with redirect_pc=7 while the queue is full -> that cycle instr_valid=0; next cycle mem_addr=7; following cycle instr_pc=7, instr=8C010020; no pre-redirect words emerge.
- Redirect to 126, ready=1 -> instr_pc sequence 126, 127, 0, 1 (wrap), all valid.
- halt=1 with 2 queued, ready=1 -> both drain, then instr_valid=0 and mem_addr constant. Release halt -> fetch resumes at the frozen PC.
- Assert reset mid-stream with the queue full -> instr_valid=0 and mem_addr=0 immediately (asynchronous, no clock edge); after release, the sequence restarts at pc 0.
